// File: rtl/alu32.sv
// ----------------------------------------------------------------------------
// alu32 : 32-bit integer ALU for the single-cycle RV32I datapath.
//
// The primary result and flags are combinational so the datapath sees them
// in the same cycle. A registered copy of result/zero is kept for debug and
// trace capture.
//
// Ports
//   clk         rising-edge clock, used only by the registered copies
//   reset       asynchronous, active-high; clears result_q, sets zero_q
//   a           operand A (rs1 or PC)
//   b           operand B (rs2 or immediate)
//   ALUControl  operation select
//                 000 ADD  001 SUB  010 AND  011 OR
//                 100 XOR  101 SLT  110 SLTU 111 PASSB
//   result      combinational result
//   zero        combinational, 1 when result == 0
//   carry       carry-out for ADD, NOT borrow for SUB, else 0
//   overflow    signed overflow for ADD/SUB, else 0
//   result_q    result registered on rising clk
//   zero_q      zero registered on rising clk
// ----------------------------------------------------------------------------
module alu32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ALUControl,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic [WIDTH-1:0] result_q,
   output logic             zero_q
);

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_SLT   = 3'b101;
   localparam logic [2:0] OP_SLTU  = 3'b110;
   localparam logic [2:0] OP_PASSB = 3'b111;

   localparam int MSB = WIDTH - 1;

   // Both adders always run: the subtractor also feeds SLT/SLTU.
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_sum;
   logic [WIDTH-1:0] b_inv;
   logic             add_ovf;
   logic             sub_ovf;
   logic             slt_bit;
   logic             sltu_bit;

   assign b_inv   = ~b;
   assign add_sum = {1'b0, a} + {1'b0, b};
   // a - b as a + ~b + 1 so bit WIDTH is the NOT-borrow carry.
   assign sub_sum = {1'b0, a} + {1'b0, b_inv} + {{WIDTH{1'b0}}, 1'b1};

   // Signed overflow: operands (with effective b) agree in sign but the
   // result sign differs from a.
   assign add_ovf = (a[MSB] == b[MSB])     && (add_sum[MSB] != a[MSB]);
   assign sub_ovf = (a[MSB] == b_inv[MSB]) && (sub_sum[MSB] != a[MSB]);

   // Sign of the difference corrected by overflow gives the true signed
   // compare even when a - b wraps (e.g. 0x80000000 vs 0x7FFFFFFF).
   assign slt_bit  = sub_sum[MSB] ^ sub_ovf;
   assign sltu_bit = ~sub_sum[WIDTH];

   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (ALUControl)
         OP_ADD: begin
            result   = add_sum[MSB:0];
            carry    = add_sum[WIDTH];
            overflow = add_ovf;
         end
         OP_SUB: begin
            result   = sub_sum[MSB:0];
            carry    = sub_sum[WIDTH];
            overflow = sub_ovf;
         end
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_SLT:   result = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_SLTU:  result = {{(WIDTH-1){1'b0}}, sltu_bit};
         OP_PASSB: result = b;
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

   // Trace registers: reset state mirrors a zero result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         result_q <= result;
         zero_q   <= zero;
      end
   end

endmodule

// File: tb/tb_alu32.sv
// ----------------------------------------------------------------------------
// tb_alu32 : self-checking bench for alu32.
// The driver issues one operation per cycle on the falling edge and pushes
// the reference model's expectation; the monitor pops one entry per rising
// edge (sampled 1 time unit later) and compares combinational and
// registered outputs.
// ----------------------------------------------------------------------------
module tb_alu32;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  ALUControl;
   logic [31:0] result;
   logic        zero;
   logic        carry;
   logic        overflow;
   logic [31:0] result_q;
   logic        zero_q;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        v;
      logic [31:0] rq;
      logic        zq;
   } exp_t;

   exp_t exp_q[$];

   alu32 #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .a          (a),
      .b          (b),
      .ALUControl (ALUControl),
      .result     (result),
      .zero       (zero),
      .carry      (carry),
      .overflow   (overflow),
      .result_q   (result_q),
      .zero_q     (zero_q)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helper ----------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Plain integer arithmetic on 64-bit values; flags from range tests.
   function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic [2:0] op, input logic rst);
      exp_t e;
      longint ua, ub, sa, sb, s;
      ua = longint'({32'b0, ma});
      ub = longint'({32'b0, mb});
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      e.c = 1'b0;
      e.v = 1'b0;
      case (op)
         3'd0: begin
            e.res = ma + mb;
            e.c   = (ua + ub) >= 64'sd4294967296;
            s     = sa + sb;
            e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd1: begin
            e.res = ma - mb;
            e.c   = (ua >= ub);
            s     = sa - sb;
            e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd2: e.res = ma & mb;
         3'd3: e.res = ma | mb;
         3'd4: e.res = ma ^ mb;
         3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
         3'd6: e.res = (ua < ub) ? 32'd1 : 32'd0;
         default: e.res = mb;
      endcase
      e.z  = (e.res == 32'd0);
      e.rq = rst ? 32'd0 : e.res;
      e.zq = rst ? 1'b1  : e.z;
      return e;
   endfunction

   // ---------------- driver ----------------
   task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [2:0] op, input logic rst);
      @(negedge clk);
      reset      = rst;
      a          = ia;
      b          = ib;
      ALUControl = op;
      exp_q.push_back(model(ia, ib, op, rst));
   endtask

   task automatic drain;
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("result",   result,           e.res);
            check("zero",     {31'b0, zero},     {31'b0, e.z});
            check("carry",    {31'b0, carry},    {31'b0, e.c});
            check("overflow", {31'b0, overflow}, {31'b0, e.v});
            check("result_q", result_q,         e.rq);
            check("zero_q",   {31'b0, zero_q},   {31'b0, e.zq});
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset      = 1'b1;
      a          = 32'd0;
      b          = 32'd0;
      ALUControl = 3'd0;
      #1;
      check("reset_result_q", result_q, 32'd0);
      check("reset_zero_q",   {31'b0, zero_q}, 32'd1);

      // a = b = 10 sweep of ADD..XOR
      for (int op = 0; op < 5; op++) issue(32'd10, 32'd10, 3'(op), 1'b0);
      // wrap and overflow corners
      issue(32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0);
      issue(32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0);
      issue(32'h8000_0000, 32'd1, 3'd1, 1'b0);
      // compares
      issue(32'hFFFF_FFFF, 32'd1, 3'd5, 1'b0);
      issue(32'hFFFF_FFFF, 32'd1, 3'd6, 1'b0);
      issue(32'h8000_0000, 32'h7FFF_FFFF, 3'd5, 1'b0);
      issue(32'd5, 32'd5, 3'd5, 1'b0);
      // PASSB leaves a nonzero value in result_q before the reset test
      issue(32'h1234_5678, 32'hABCD_E000, 3'd7, 1'b0);
      drain();

      // spec constants the model must also agree with
      a = 32'h7FFF_FFFF; b = 32'd1; ALUControl = 3'd0;
      #1;
      check("k_add_ovf_result", result, 32'h8000_0000);
      check("k_add_ovf_flag",   {31'b0, overflow}, 32'd1);
      a = 32'h8000_0000; b = 32'h7FFF_FFFF; ALUControl = 3'd5;
      #1;
      check("k_slt_corrected", result, 32'd1);
      a = 32'h1234_5678; b = 32'hABCD_E000; ALUControl = 3'd7;
      #1;
      check("k_passb", result, 32'hABCD_E000);

      // asynchronous reset mid-cycle
      @(negedge clk);
      check("pre_reset_result_q", result_q, 32'hABCD_E000);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_result_q", result_q, 32'd0);
      check("async_reset_zero_q",   {31'b0, zero_q}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      a = 32'd3; b = 32'd4; ALUControl = 3'd0;
      #1;
      check("add34_comb",        result,   32'd7);
      check("add34_before_edge", result_q, 32'd0);
      @(posedge clk);
      #1;
      check("add34_result_q", result_q, 32'd7);
      check("add34_zero_q",   {31'b0, zero_q}, 32'd0);

      // random regression with random reset pulses
      for (int i = 0; i < 10000; i++) begin
         issue($urandom, $urandom, 3'($urandom_range(0, 7)),
               ($urandom_range(0, 39) == 0));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu32.md
Name: alu32

Overview:
- 32-bit integer ALU for the single-cycle RV32I datapath.
- Computes arithmetic, logic and compare results from two operands under a 3-bit control code supplied by the ALU decoder.
- Primary result is combinational, so the single-cycle path sees it in the same cycle.
- A registered copy of the result and flags is provided for debug and trace capture.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported for RV32I.

Ports:
- clk  input  1  system clock, rising-edge; clocks the registered copies only.
- reset  input  1  asynchronous, active-high; clears registered outputs.
- a  input  32  operand A (rs1 or PC).
- b  input  32  operand B (rs2 or immediate).
- ALUControl  input  3  operation select.
- result  output  32  combinational operation result.
- zero  output  1  combinational; 1 when result == 0.
- carry  output  1  combinational carry-out (add) or NOT borrow (sub); 0 for other ops.
- overflow  output  1  combinational signed overflow for add/sub; 0 for other ops.
- result_q  output  32  result registered on rising clk.
- zero_q  output  1  zero registered on rising clk.

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- ALUControl encoding:
  - 000 ADD: a + b, modulo 2^32.
  - 001 SUB: a - b, modulo 2^32, implemented as a + ~b + 1.
  - 010 AND: a & b.
  - 011 OR: a | b.
  - 100 XOR: a ^ b.
  - 101 SLT: 1 if $signed(a) < $signed(b), else 0; zero-extended to 32 bits.
  - 110 SLTU: 1 if a < b unsigned, else 0; zero-extended.
  - 111 PASSB: b (used for LUI).
- result, zero, carry and overflow are purely combinational, with zero-cycle latency from a, b and ALUControl.
- They do not depend on clk or reset; reset does not affect them.
- Flags:
  - carry = bit 32 of the 33-bit sum for ADD and SUB.
  - overflow = (a[31] == b_eff[31]) && (result[31] != a[31]), where b_eff = b for ADD and ~b for SUB.
  - SLT is computed as (sub_result[31] XOR sub_overflow), not by a naive sign-bit test.
  - SLTU is computed as NOT sub_carry.
- Registered outputs:
  - On reset assertion, result_q = 0 and zero_q = 1 immediately, with no clock needed.
  - While reset is high, both hold those values.
  - After reset deassertion, each rising clk edge captures result_q <= result and zero_q <= zero, giving one-cycle latency.
  - If reset deasserts coincident with a clock edge, that edge does not capture.
- No internal state other than the two output registers; no handshake; a new operation is accepted every evaluation.
- All arithmetic is 32-bit wrap-around; no exceptions or traps are raised.

Test Plan:
- a=10, b=10, sweep ALUControl 000..100:
  - ADD = 20.
  - SUB = 0 with zero=1, carry=1.
  - AND = 10.
  - OR = 10.
  - XOR = 0 with zero=1.
  - All results must be valid within the same timestep, no clock required.
- Overflow/wrap:
  - ADD 0x7FFFFFFF + 1 -> 0x80000000, overflow=1, carry=0.
  - ADD 0xFFFFFFFF + 1 -> 0, carry=1, zero=1, overflow=0.
  - SUB 0x80000000 - 1 -> 0x7FFFFFFF, overflow=1.
- Compares:
  - SLT a=0xFFFFFFFF(-1), b=1 -> 1.
  - SLTU with the same operands -> 0.
  - SLT a=0x80000000, b=0x7FFFFFFF -> 1 (requires the overflow-corrected compare).
  - SLT a=b=5 -> 0.
- PASSB: a=0x12345678, b=0xABCDE000, ALUControl=111 -> result=0xABCDE000; carry=0, overflow=0.
- Registered path:
  - Assert reset mid-cycle -> result_q=0 and zero_q=1 immediately.
  - Release reset, then ADD 3+4 -> result_q=7, zero_q=0 after the next rising edge.
  - Before that edge, result_q still reads 0.
- Random regression: 10,000 random a, b and ALUControl values checked against a behavioural model for result and all flags, with reset pulsed randomly.
